// File: rtl/x86_dec_pkg.sv
// Shared types and helpers for the x86 instruction field decoder:
// FSM states, prefix bit positions, immediate codes and length limit.
package x86_dec_pkg;

    localparam int MAX_INSN_LEN = 15;

    typedef enum logic [2:0] {
        S_PREFIX,
        S_OPCODE2,
        S_MODRM,
        S_SIB,
        S_DISP,
        S_IMM,
        S_EMIT
    } dec_state_t;

    localparam int PFX_LOCK  = 0;
    localparam int PFX_REPNE = 1;
    localparam int PFX_REP   = 2;
    localparam int PFX_SEG   = 3;
    localparam int PFX_OPSZ  = 4;
    localparam int PFX_ADSZ  = 5;

    localparam logic [1:0] IMM_NONE  = 2'd0;
    localparam logic [1:0] IMM_8     = 2'd1;
    localparam logic [1:0] IMM_16    = 2'd2;
    localparam logic [1:0] IMM_16_32 = 2'd3;

    typedef struct packed {
        logic [3:0]  len;
        logic [7:0]  prefix;
        logic [3:0]  rex;
        logic        rex_vld;
        logic [7:0]  opcode;
        logic        two_byte;
        logic [7:0]  modrm;
        logic        modrm_vld;
        logic [7:0]  sib;
        logic        sib_vld;
        logic [31:0] disp;
        logic [63:0] imm;
        logic        err;
    } dec_rec_t;

    // One-hot legacy-prefix mask; zero for any byte that is not a legacy prefix.
    function automatic logic [7:0] prefix_mask(input logic [7:0] b);
        prefix_mask = 8'h00;
        case (b)
            8'hF0: prefix_mask[PFX_LOCK]  = 1'b1;
            8'hF2: prefix_mask[PFX_REPNE] = 1'b1;
            8'hF3: prefix_mask[PFX_REP]   = 1'b1;
            8'h26, 8'h2E, 8'h36, 8'h3E, 8'h64, 8'h65: prefix_mask[PFX_SEG] = 1'b1;
            8'h66: prefix_mask[PFX_OPSZ]  = 1'b1;
            8'h67: prefix_mask[PFX_ADSZ]  = 1'b1;
            default: ;
        endcase
    endfunction

    function automatic logic [3:0] imm_bytes(input logic [1:0] code, input logic opsz16,
                                             input logic wide);
        if (wide) return 4'd8;
        case (code)
            IMM_8:     return 4'd1;
            IMM_16:    return 4'd2;
            IMM_16_32: return opsz16 ? 4'd2 : 4'd4;
            default:   return 4'd0;
        endcase
    endfunction

    // Displacement implied by ModRM alone; the SIB-base case is handled later.
    function automatic logic [2:0] modrm_disp_bytes(input logic [7:0] modrm);
        case (modrm[7:6])
            2'b01:   return 3'd1;
            2'b10:   return 3'd4;
            2'b00:   return (modrm[2:0] == 3'b101) ? 3'd4 : 3'd0;
            default: return 3'd0;
        endcase
    endfunction

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
    endfunction

endpackage

// File: rtl/x86_byte_queue.sv
// Circular byte FIFO: up to FETCH_BYTES bytes pushed per cycle, one byte popped
// per cycle, with occupancy count and a "room for a full beat" flag.
module x86_byte_queue #(
    parameter int FETCH_BYTES = 8,
    parameter int BUF_DEPTH   = 32,
    localparam int CW  = $clog2(FETCH_BYTES + 1),
    localparam int PW  = $clog2(BUF_DEPTH),
    localparam int QCW = PW + 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic [8*FETCH_BYTES-1:0] push_bytes,
    input  logic [CW-1:0]            push_count,
    input  logic                     pop,
    output logic [7:0]               head,
    output logic [QCW-1:0]           count,
    output logic                     can_push
);

    logic [7:0]     mem [BUF_DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [QCW-1:0] cnt;
    logic [QCW-1:0] push_n;

    assign push_n   = push ? QCW'(push_count) : '0;
    assign head     = mem[rd_ptr];
    assign count    = cnt;
    assign can_push = (QCW'(BUF_DEPTH) - cnt) >= QCW'(FETCH_BYTES);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(push_n);
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            cnt <= cnt + push_n - QCW'(pop);
        end
    end

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            for (int i = 0; i < FETCH_BYTES; i++) begin
                if (i < int'(push_count)) mem[wr_ptr + PW'(i)] <= push_bytes[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/x86_field_decoder.sv
// Byte-serial x86 instruction field decoder fed from a fetch byte queue.
// Optional DEC_HEX_TRACE_EN adds a dec_hex ASCII dump of the instruction bytes.
module x86_field_decoder
    import x86_dec_pkg::*;
#(
    parameter int FETCH_BYTES = 8,
    parameter int BUF_DEPTH   = 32
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               flush,
    input  logic [63:0]                        flush_addr,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [8*FETCH_BYTES-1:0]           in_bytes,
    input  logic [$clog2(FETCH_BYTES+1)-1:0]   in_count,
    input  logic [255:0]                       modrm_map,
    input  logic [255:0]                       modrm_map2,
    input  logic [511:0]                       imm_map,
    input  logic [511:0]                       imm_map2,
    output logic                               dec_valid,
    input  logic                               dec_ready,
    output logic [63:0]                        dec_addr,
    output logic [3:0]                         dec_len,
    output logic [7:0]                         dec_prefix,
    output logic [3:0]                         dec_rex,
    output logic                               dec_rex_vld,
    output logic [7:0]                         dec_opcode,
    output logic                               dec_two_byte,
    output logic [7:0]                         dec_modrm,
    output logic                               dec_modrm_vld,
    output logic [7:0]                         dec_sib,
    output logic                               dec_sib_vld,
    output logic [31:0]                        dec_disp,
    output logic [63:0]                        dec_imm,
    output logic                               dec_err
`ifdef DEC_HEX_TRACE_EN
    ,
    output logic [359:0]                       dec_hex
`endif
);

    localparam int QCW = $clog2(BUF_DEPTH) + 1;

    dec_state_t     st, st_nxt, op_next, imm_tail;
    dec_rec_t       rec;
    logic [63:0]    addr;
    logic [2:0]     disp_size;
    logic [3:0]     imm_size;
    logic [2:0]     fidx;

    logic [7:0]     q_byte;
    logic [QCW-1:0] q_count;
    logic           push, consume, len_err;
    logic           op_two, op_modrm, op_wide, is_rex, m_sib, last_disp, last_imm;
    logic [1:0]     op_code;
    logic [3:0]     op_isz;
    logic [7:0]     pfx;
    logic [2:0]     m_dsz, s_dsz;

    assign push    = in_valid && in_ready && !flush;
    assign consume = !flush && (st != S_EMIT) && (q_count != '0);

    x86_byte_queue #(
        .FETCH_BYTES (FETCH_BYTES),
        .BUF_DEPTH   (BUF_DEPTH)
    ) u_queue (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .push       (push),
        .push_bytes (in_bytes),
        .push_count (in_count),
        .pop        (consume),
        .head       (q_byte),
        .count      (q_count),
        .can_push   (in_ready)
    );

    // Per-byte field decode of the queue head in the context of the current state.
    assign op_two    = (st == S_OPCODE2);
    assign op_modrm  = op_two ? modrm_map2[q_byte] : modrm_map[q_byte];
    assign op_code   = op_two ? imm_map2[{q_byte, 1'b0} +: 2] : imm_map[{q_byte, 1'b0} +: 2];
    assign op_wide   = !op_two && (q_byte[7:3] == 5'b10111) && rec.rex_vld && rec.rex[3];
    assign op_isz    = imm_bytes(op_code, rec.prefix[PFX_OPSZ], op_wide);
    assign pfx       = prefix_mask(q_byte);
    assign is_rex    = (q_byte[7:4] == 4'h4);
    assign m_sib     = (q_byte[7:6] != 2'b11) && (q_byte[2:0] == 3'b100);
    assign m_dsz     = modrm_disp_bytes(q_byte);
    assign s_dsz     = (rec.modrm[7:6] == 2'b00 && q_byte[2:0] == 3'b101) ? 3'd4 : disp_size;
    assign last_disp = (fidx == disp_size - 3'd1);
    assign last_imm  = ({1'b0, fidx} == imm_size - 4'd1);
    assign op_next   = op_modrm ? S_MODRM : ((op_isz != 4'd0) ? S_IMM : S_EMIT);
    assign imm_tail  = (imm_size != 4'd0) ? S_IMM : S_EMIT;

    always_comb begin
        st_nxt  = st;
        len_err = 1'b0;
        if (st == S_EMIT) begin
            if (dec_ready) st_nxt = S_PREFIX;
        end else if (consume) begin
            case (st)
                S_PREFIX: begin
                    if (pfx != 8'h00 || is_rex) st_nxt = S_PREFIX;
                    else if (q_byte == 8'h0F)   st_nxt = S_OPCODE2;
                    else                        st_nxt = op_next;
                end
                S_OPCODE2: st_nxt = op_next;
                S_MODRM:   st_nxt = m_sib ? S_SIB : ((m_dsz != 3'd0) ? S_DISP : imm_tail);
                S_SIB:     st_nxt = (s_dsz != 3'd0) ? S_DISP : imm_tail;
                S_DISP:    st_nxt = last_disp ? imm_tail : S_DISP;
                S_IMM:     st_nxt = last_imm ? S_EMIT : S_IMM;
                default:   st_nxt = S_PREFIX;
            endcase
            // Byte 15 consumed without completing: cut the instruction off here.
            if (st_nxt != S_EMIT && rec.len == 4'(MAX_INSN_LEN - 1)) begin
                st_nxt  = S_EMIT;
                len_err = 1'b1;
            end
        end
        if (flush) st_nxt = S_PREFIX;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st        <= S_PREFIX;
            addr      <= '0;
            rec       <= '0;
            disp_size <= '0;
            imm_size  <= '0;
            fidx      <= '0;
        end else if (flush) begin
            st        <= S_PREFIX;
            addr      <= flush_addr;
            rec       <= '0;
            disp_size <= '0;
            imm_size  <= '0;
            fidx      <= '0;
        end else begin
            st <= st_nxt;
            if (st == S_EMIT) begin
                if (dec_ready) begin
                    addr      <= addr + 64'(rec.len);
                    rec       <= '0;
                    disp_size <= '0;
                    imm_size  <= '0;
                    fidx      <= '0;
                end
            end else if (consume) begin
                rec.len <= rec.len + 4'd1;
                rec.err <= len_err;
                case (st)
                    S_PREFIX: begin
                        if (pfx != 8'h00) begin
                            rec.prefix  <= rec.prefix | pfx;
                            rec.rex     <= 4'h0;
                            rec.rex_vld <= 1'b0;
                        end else if (is_rex) begin
                            rec.rex     <= q_byte[3:0];
                            rec.rex_vld <= 1'b1;
                        end else if (q_byte == 8'h0F) begin
                            rec.two_byte <= 1'b1;
                        end else begin
                            rec.opcode <= q_byte;
                            imm_size   <= op_isz;
                        end
                    end
                    S_OPCODE2: begin
                        rec.opcode <= q_byte;
                        imm_size   <= op_isz;
                    end
                    S_MODRM: begin
                        rec.modrm     <= q_byte;
                        rec.modrm_vld <= 1'b1;
                        disp_size     <= m_dsz;
                        fidx          <= '0;
                    end
                    S_SIB: begin
                        rec.sib     <= q_byte;
                        rec.sib_vld <= 1'b1;
                        disp_size   <= s_dsz;
                    end
                    S_DISP: begin
                        if (disp_size == 3'd1) rec.disp <= {{24{q_byte[7]}}, q_byte};
                        else                   rec.disp[8*fidx[1:0] +: 8] <= q_byte;
                        fidx <= last_disp ? 3'd0 : fidx + 3'd1;
                    end
                    S_IMM: begin
                        rec.imm[8*fidx +: 8] <= q_byte;
                        fidx <= fidx + 3'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign dec_valid     = (st == S_EMIT);
    assign dec_addr      = addr;
    assign dec_len       = rec.len;
    assign dec_prefix    = rec.prefix;
    assign dec_rex       = rec.rex;
    assign dec_rex_vld   = rec.rex_vld;
    assign dec_opcode    = rec.opcode;
    assign dec_two_byte  = rec.two_byte;
    assign dec_modrm     = rec.modrm;
    assign dec_modrm_vld = rec.modrm_vld;
    assign dec_sib       = rec.sib;
    assign dec_sib_vld   = rec.sib_vld;
    assign dec_disp      = rec.disp;
    assign dec_imm       = rec.imm;
    assign dec_err       = rec.err;

`ifdef DEC_HEX_TRACE_EN
    logic [7:0] ibuf [MAX_INSN_LEN];

    always_ff @(posedge clk) begin
        if (consume) ibuf[rec.len] <= q_byte;
    end

    // First instruction byte lands in the most-significant "xx " triplet.
    always_comb begin
        dec_hex = '0;
        if (dec_valid) begin
            for (int i = 0; i < MAX_INSN_LEN; i++) begin
                dec_hex[359-24*i -: 24] = (i < int'(rec.len)) ?
                    {hex_char(ibuf[i][7:4]), hex_char(ibuf[i][3:0]), 8'h20} : 24'h202020;
            end
        end
    end
`endif

endmodule
